pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives the we/empty pair of every
//  inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable. Resolves
//  data-memory wait, taken branch/jump and load-use hazards. Keeps a stall-cycle perf counter
//  and a sticky memory-timeout flag.
// PARAMETERS
//  BRANCH_PENALTY  2     cycles IF/ID is bubbled after a taken branch (>=1)
//  MEM_TIMEOUT     255   consecutive mem_busy cycles before mem_timeout sets (>=1)
//  CNT_W           32    width of stall_cycles
// PORTS
//  clk            in   1      clock, single domain
//  rst            in   1      synchronous reset, active-high
//  id_rs1         in   5      source reg 1 of instruction in ID
//  id_rs2         in   5      source reg 2 of instruction in ID
//  id_use_rs1     in   1      ID instruction reads rs1
//  id_use_rs2     in   1      ID instruction reads rs2
//  ex_rd          in   5      dest reg of instruction in EX
//  ex_mem_read    in   1      EX instruction is a load
//  branch_taken   in   1      EX resolved taken branch/jump (PC target valid this cycle)
//  mem_busy       in   1      data memory not ready; MEM stage must hold
//  pc_we          out  1      PC write enable
//  if_id_we, id_ex_we, ex_mem_we, mem_wb_we           out 1  register write enables
//  if_id_empty, id_ex_empty, ex_mem_empty, mem_wb_empty out 1  load bubble (zero) when we=1
//  stall_cycles   out  CNT_W  cycles with pc_we=0 since reset, saturating
//  mem_timeout    out  1      sticky: mem_busy held MEM_TIMEOUT consecutive cycles
// BEHAVIOUR
//  - State reg {RUN, FLUSH}; flush_cnt (clog2 BRANCH_PENALTY+1 bits); wait_cnt (8+ bits).
//  - Outputs combinational from state + inputs; state/counters update on posedge clk.
//  - rst=1: next state RUN, flush_cnt=0, wait_cnt=0, stall_cycles=0, mem_timeout=0.
//    While rst=1 outputs: pc_we=0, all *_we=1, all *_empty=1.
//  - Default (no hazard): pc_we=1, all we=1, all empty=0.
//  - Priority per cycle, highest first (applies in both states):
//    1 mem_busy: pc_we, if_id_we, id_ex_we, ex_mem_we=0; mem_wb_we=1, mem_wb_empty=1.
//      wait_cnt++ (saturating); flush_cnt and state frozen. wait_cnt cleared when mem_busy=0.
//      wait_cnt reaching MEM_TIMEOUT sets mem_timeout; cleared only by rst.
//    2 branch_taken (only honoured in RUN): pc_we=1, if_id_empty=1, id_ex_empty=1, all we=1.
//      BRANCH_PENALTY=1: stay RUN. Else -> FLUSH, flush_cnt=BRANCH_PENALTY-1.
//    3 FLUSH: pc_we=1, if_id_empty=1, others default. flush_cnt--; at 1 -> RUN next cycle.
//      branch_taken and load-use ignored (EX/ID hold bubbles).
//    4 load-use (RUN): ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) |
//      (id_use_rs2 & id_rs2==ex_rd)) -> pc_we=0, if_id_we=0, id_ex_empty=1; exactly one cycle
//      since bubble clears ex_mem_read.
//  - stall_cycles increments every non-reset cycle with pc_we=0; holds at all-ones.
//  - x0 never creates a hazard. Branch + load-use same cycle: branch wins (ID is squashed).
//  - Reset mid-FLUSH or mid-wait: aborts immediately, RUN next cycle, counters zeroed.
// TESTING
//  1 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle pc_we=0,
//    if_id_we=0, id_ex_empty=1; stall_cycles 0->1; ex_rd=0 same case -> no stall.
//  2 Branch, BRANCH_PENALTY=2: branch_taken 1 cycle -> cycle0 if_id_empty=id_ex_empty=1,
//    cycle1 if_id_empty=1 only, cycle2 defaults; pc_we=1 throughout; stall_cycles unchanged.
//  3 mem_busy 3 cycles during FLUSH -> 3 frozen cycles (mem_wb_empty=1), then remaining
//    flush cycle completes; stall_cycles +3.
//  4 MEM_TIMEOUT=4: mem_busy held 6 cycles -> mem_timeout=1 from 5th cycle edge, stays 1
//    after mem_busy drops; rst clears it.
//  5 branch_taken and load-use together -> branch response, no pc stall; rst asserted in
//    FLUSH -> all *_empty=1, next cycle RUN defaults.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline
// Handles data-memory wait, taken branches and load-use hazards. Also keeps stall and timeout status.
module pipeline_hazard_ctrl #(
    parameter int BRANCH_PENALTY = 2,
    parameter int MEM_TIMEOUT    = 255,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_empty,
    output logic             id_ex_empty,
    output logic             ex_mem_empty,
    output logic             mem_wb_empty,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mem_timeout
);
    localparam int FW = $clog2(BRANCH_PENALTY + 1);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam int WW = TW > 8 ? TW : 8;
    typedef enum logic {RUN, FLUSH} state_t;
    state_t           r_state, w_next;
    logic [FW-1:0]    r_flush_cnt, w_flush_next;
    logic [WW-1:0]    r_wait_cnt;
    logic [CNT_W-1:0] r_stall;
    logic             r_mem_timeout;
    logic             w_load_use;
    assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                        ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    assign stall_cycles = r_stall;
    assign mem_timeout  = r_mem_timeout;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_flush_cnt   <= '0;
            r_wait_cnt    <= '0;
            r_stall       <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_flush_cnt   <= w_flush_next;
            r_wait_cnt    <= mem_busy ? (&r_wait_cnt ? r_wait_cnt : r_wait_cnt + 1'b1) : '0;
            r_mem_timeout <= r_mem_timeout | (r_wait_cnt >= WW'(MEM_TIMEOUT));
            r_stall       <= (!pc_we && !(&r_stall)) ? r_stall + 1'b1 : r_stall;
        end
    end
    // A busy memory freezes the sequencer so a pending flush resumes once it clears
    always_comb begin
        w_next       = r_state;
        w_flush_next = r_flush_cnt;
        if (rst) begin
            w_next       = RUN;
            w_flush_next = '0;
        end else if (mem_busy) begin
            w_next = r_state;
        end else if (r_state == RUN && branch_taken) begin
            w_next       = (BRANCH_PENALTY > 1) ? FLUSH : RUN;
            w_flush_next = (BRANCH_PENALTY > 1) ? FW'(BRANCH_PENALTY - 1) : '0;
        end else if (r_state == FLUSH) begin
            w_flush_next = r_flush_cnt - 1'b1;
            w_next       = (r_flush_cnt == FW'(1)) ? RUN : FLUSH;
        end
    end
    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_we     = 1'b1;
        ex_mem_we    = 1'b1;
        mem_wb_we    = 1'b1;
        if_id_empty  = 1'b0;
        id_ex_empty  = 1'b0;
        ex_mem_empty = 1'b0;
        mem_wb_empty = 1'b0;
        if (rst) begin
            pc_we        = 1'b0;
            if_id_empty  = 1'b1;
            id_ex_empty  = 1'b1;
            ex_mem_empty = 1'b1;
            mem_wb_empty = 1'b1;
        end else if (mem_busy) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            mem_wb_empty = 1'b1;
        end else if (r_state == RUN && branch_taken) begin
            if_id_empty = 1'b1;
            id_ex_empty = 1'b1;
        end else if (r_state == FLUSH) begin
            if_id_empty = 1'b1;
        end else if (w_load_use) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_empty = 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and randomized checks against a cycle-level reference model
module tb_pipeline_hazard_ctrl;
    localparam int BP = 2, MT = 4, CW = 4;
    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_read, branch_taken, mem_busy;
    logic          pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic          if_id_empty, id_ex_empty, ex_mem_empty, mem_wb_empty;
    logic [CW-1:0] stall_cycles;
    logic          mem_timeout;
    int            n_chk = 0, n_pass = 0;
    int            m_flush = 0, m_run = 0, m_stall = 0;
    logic          m_to = 1'b0;

    pipeline_hazard_ctrl #(.BRANCH_PENALTY(BP), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
        .mem_wb_we(mem_wb_we), .if_id_empty(if_id_empty), .id_ex_empty(id_ex_empty),
        .ex_mem_empty(ex_mem_empty), .mem_wb_empty(mem_wb_empty),
        .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic idle();
        {id_rs1, id_rs2, ex_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_mem_read, branch_taken, mem_busy} = '0;
    endtask

    // expected control word: {pc_we, we[if_id,id_ex,ex_mem,mem_wb], empty[if_id,id_ex,ex_mem,mem_wb]}
    task automatic cycle(input string tag);
        logic [8:0] e;
        logic       lu;
        lu = ex_mem_read && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (rst)                            e = 9'b0_1111_1111;
        else if (mem_busy)                  e = 9'b0_0001_0001;
        else if (m_flush == 0 && branch_taken) e = 9'b1_1111_1100;
        else if (m_flush > 0)               e = 9'b1_1111_1000;
        else if (lu)                        e = 9'b0_0111_0100;
        else                                e = 9'b1_1111_0000;
        @(negedge clk);
        check({tag, "_ctl"}, {23'd0, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_empty, id_ex_empty, ex_mem_empty, mem_wb_empty}, {23'd0, e});
        check({tag, "_stall"}, {28'd0, stall_cycles}, m_stall);
        check({tag, "_tmo"}, {31'd0, mem_timeout}, {31'd0, m_to});
        if (rst) begin
            m_flush = 0; m_run = 0; m_stall = 0; m_to = 1'b0;
        end else begin
            if (!e[8] && m_stall < (1 << CW) - 1) m_stall++;
            if (m_run >= MT) m_to = 1'b1;
            if (mem_busy) m_run++;
            else begin
                m_run = 0;
                if (m_flush > 0) m_flush--;
                else if (branch_taken) m_flush = BP - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        cycle("rst");
        rst = 1'b0;
        cycle("idle");
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        cycle("lu");
        ex_mem_read = 1'b0;
        cycle("lu_after");
        check("lu_cnt", {28'd0, stall_cycles}, 32'd1);
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        cycle("lu_x0");
        idle();
        branch_taken = 1'b1;
        cycle("br0");
        branch_taken = 1'b0;
        cycle("br1");
        cycle("br2");
        branch_taken = 1'b1;
        cycle("fb0");
        branch_taken = 1'b0; mem_busy = 1'b1;
        repeat (3) cycle("fb_busy");
        mem_busy = 1'b0;
        cycle("fb_rest");
        cycle("fb_done");
        mem_busy = 1'b1;
        repeat (6) cycle("tmo_busy");
        mem_busy = 1'b0;
        cycle("tmo_idle");
        check("tmo_sticky", {31'd0, mem_timeout}, 32'd1);
        rst = 1'b1;
        cycle("tmo_rst");
        rst = 1'b0;
        cycle("tmo_clr");
        branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        cycle("br_lu");
        idle();
        rst = 1'b1;
        cycle("fl_rst");
        rst = 1'b0;
        cycle("fl_run");
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom % 60) == 0;
            mem_busy     = ($urandom % 8 == 0) || (mem_busy && $urandom % 4 != 0);
            branch_taken = ($urandom % 6) == 0;
            ex_mem_read  = $urandom % 2;
            ex_rd        = 5'($urandom % 4);
            id_rs1       = 5'($urandom % 4);
            id_rs2       = 5'($urandom % 4);
            id_use_rs1   = $urandom % 2;
            id_use_rs2   = $urandom % 2;
            cycle("rnd");
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
